// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO sitting between the hart's MMIO write path and serial_transmitter.
//
// Register map (byte addresses):
//   BASE_ADDR + 0x00  DATA    byte write pushes value[7:0]; wider writes set width_err
//   BASE_ADDR + 0x10  STATUS  {count[16:8], tx_busy, width_err, full, empty}; write value[0]=1 clears width_err
//   BASE_ADDR + 0x14  CTRL    bit0 tx_enable (r/w); write value[1]=1 flushes the FIFO
//
// Ports:
//   core_clock           clock, rising edge
//   reset                synchronous, active-high
//   mmio_addr/enable/width/value   write request, held stable until mmio_write_complete
//   mmio_hit             address decodes to one of the three registers
//   mmio_write_complete  combinational write acknowledge
//   mmio_r_data          combinational read data for mmio_addr
//   tx_data              FIFO head byte
//   tx_data_available    tx_data is valid
//   tx_ready             transmitter takes the head byte this cycle
module uart_tx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0003_0000
) (
  input  logic        core_clock,
  input  logic        reset,
  input  logic [31:0] mmio_addr,
  input  logic        mmio_enable,
  input  logic [1:0]  mmio_width,
  input  logic [31:0] mmio_value,
  output logic        mmio_hit,
  output logic        mmio_write_complete,
  output logic [31:0] mmio_r_data,
  output logic [7:0]  tx_data,
  output logic        tx_data_available,
  input  logic        tx_ready
);

  localparam int unsigned AW          = $clog2(DEPTH);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'h10;
  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + 32'h14;
  localparam logic [AW:0] FULL_COUNT  = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_count;
  logic          r_tx_enable;
  logic          r_width_err;

  logic w_sel_data;
  logic w_sel_status;
  logic w_sel_ctrl;
  logic w_empty;
  logic w_full;
  logic w_byte;
  logic w_data_wr;
  logic w_push;
  logic w_wide;
  logic w_status_wr;
  logic w_ctrl_wr;
  logic w_flush;
  logic w_pop;
  logic w_unused_value;

  assign w_sel_data   = (mmio_addr == BASE_ADDR);
  assign w_sel_status = (mmio_addr == STATUS_ADDR);
  assign w_sel_ctrl   = (mmio_addr == CTRL_ADDR);
  assign mmio_hit     = w_sel_data | w_sel_status | w_sel_ctrl;

  // Fullness comes from the registered count only, so a stalled write cannot
  // sneak in on the same edge that a pop frees a slot.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);

  assign w_byte      = (mmio_width == 2'd0);
  assign w_data_wr   = !reset && mmio_enable && w_sel_data;
  assign w_push      = w_data_wr && w_byte && !w_full;
  assign w_wide      = w_data_wr && !w_byte;
  assign w_status_wr = !reset && mmio_enable && w_sel_status;
  assign w_ctrl_wr   = !reset && mmio_enable && w_sel_ctrl;
  assign w_flush     = w_ctrl_wr && mmio_value[1];

  assign tx_data_available   = !reset && !w_empty && r_tx_enable;
  assign w_pop               = tx_data_available && tx_ready && !w_flush;
  assign tx_data             = r_mem[r_rptr];
  assign mmio_write_complete = w_push || w_wide || w_status_wr || w_ctrl_wr;

  assign w_unused_value = &{1'b0, mmio_value[31:8]};

  always_comb begin
    mmio_r_data = '0;
    if (w_sel_status) begin
      mmio_r_data = {15'd0, 9'(r_count), 4'd0,
                     tx_data_available, r_width_err, w_full, w_empty};
    end else if (w_sel_ctrl) begin
      mmio_r_data = {31'd0, r_tx_enable};
    end
  end

  always_ff @(posedge core_clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= mmio_value[7:0];
    end
  end

  always_ff @(posedge core_clock) begin
    if (reset) begin
      r_rptr      <= '0;
      r_wptr      <= '0;
      r_count     <= '0;
      r_width_err <= 1'b0;
      r_tx_enable <= 1'b1;
    end else begin
      // A flush only ever coincides with a CTRL write, so no push can be lost here.
      if (w_flush) begin
        r_rptr  <= '0;
        r_wptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - (AW+1)'(1);
        end
      end

      if (w_wide) begin
        r_width_err <= 1'b1;
      end else if (w_status_wr && mmio_value[0]) begin
        r_width_err <= 1'b0;
      end

      if (w_ctrl_wr) begin
        r_tx_enable <= mmio_value[0];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo: decode/read-data vector table, directed
// multi-cycle sequences (latency, stall, width error, enable/flush, reset) and a
// randomized transfer compared against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int          DEPTH    = 16;
  localparam logic [31:0] BASE     = 32'h0003_0000;
  localparam logic [31:0] DATA_A   = BASE;
  localparam logic [31:0] STATUS_A = BASE + 32'h10;
  localparam logic [31:0] CTRL_A   = BASE + 32'h14;

  logic        core_clock;
  logic        reset;
  logic [31:0] mmio_addr;
  logic        mmio_enable;
  logic [1:0]  mmio_width;
  logic [31:0] mmio_value;
  logic        mmio_hit;
  logic        mmio_write_complete;
  logic [31:0] mmio_r_data;
  logic [7:0]  tx_data;
  logic        tx_data_available;
  logic        tx_ready;

  uart_tx_fifo #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .core_clock          (core_clock),
    .reset               (reset),
    .mmio_addr           (mmio_addr),
    .mmio_enable         (mmio_enable),
    .mmio_width          (mmio_width),
    .mmio_value          (mmio_value),
    .mmio_hit            (mmio_hit),
    .mmio_write_complete (mmio_write_complete),
    .mmio_r_data         (mmio_r_data),
    .tx_data             (tx_data),
    .tx_data_available   (tx_data_available),
    .tx_ready            (tx_ready)
  );

  initial core_clock = 1'b0;
  always #50 core_clock = ~core_clock;

  // Reference model: byte queue in push order plus the two control bits.
  logic [7:0] exp_q[$];
  bit         exp_en   = 1'b1;
  bit         exp_werr = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;
  bit rnd_done = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic        en;
    logic [1:0]  width;
    logic        exp_hit;
    logic        exp_cmp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_status();
    int c;
    logic [31:0] s;
    c = exp_q.size();
    s = 32'(c) << 8;
    if (c != 0 && exp_en) s = s | 32'h8;
    if (exp_werr)         s = s | 32'h4;
    if (c == DEPTH)       s = s | 32'h2;
    if (c == 0)           s = s | 32'h1;
    return s;
  endfunction

  task automatic tick();
    @(posedge core_clock);
    #1;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    mmio_enable = 1'b0;
    mmio_addr   = a;
    #1;
    chk(name, mmio_r_data, exp);
  endtask

  // Holds the request until acknowledged (bounded), updates the model, then releases.
  task automatic bus_write(input logic [31:0] a, input logic [1:0] w, input logic [31:0] v,
                           input int max_wait, output int waited);
    mmio_addr   = a;
    mmio_width  = w;
    mmio_value  = v;
    mmio_enable = 1'b1;
    #1;
    waited = 0;
    while (!mmio_write_complete && waited < max_wait) begin
      tick();
      waited++;
    end
    chk("write_done", {31'd0, mmio_write_complete}, 32'd1);
    if (mmio_write_complete) begin
      if (a == DATA_A) begin
        if (w == 2'd0) exp_q.push_back(v[7:0]);
        else exp_werr = 1'b1;
      end else if (a == STATUS_A) begin
        if (v[0]) exp_werr = 1'b0;
      end else if (a == CTRL_A) begin
        exp_en = v[0];
        if (v[1]) exp_q.delete();
      end
      tick();
    end
    mmio_enable = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    tx_ready = 1'b1;
    k = 0;
    while (tx_data_available && k < 200) begin
      tick();
      k++;
    end
    chk("drain_done", {31'd0, tx_data_available}, 32'd0);
    rd_check("drain_status", STATUS_A, exp_status());
  endtask

  // Every transfer to the transmitter must be the oldest byte still queued.
  always @(negedge core_clock) begin
    if (!reset && tx_data_available && tx_ready &&
        !(mmio_enable && mmio_addr == CTRL_A && mmio_value[1])) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got byte 0x%0h expected none queued", tx_data);
      end else begin
        chk("pop_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int pops0;

    vecs[0]  = '{DATA_A,         1'b0, 2'd0, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{DATA_A,         1'b1, 2'd0, 1'b1, 1'b1, 32'h0};
    vecs[2]  = '{DATA_A,         1'b1, 2'd2, 1'b1, 1'b1, 32'h0};
    vecs[3]  = '{STATUS_A,       1'b0, 2'd0, 1'b1, 1'b0, 32'h1};
    vecs[4]  = '{STATUS_A,       1'b1, 2'd2, 1'b1, 1'b1, 32'h1};
    vecs[5]  = '{CTRL_A,         1'b0, 2'd0, 1'b1, 1'b0, 32'h1};
    vecs[6]  = '{CTRL_A,         1'b1, 2'd0, 1'b1, 1'b1, 32'h1};
    vecs[7]  = '{BASE + 32'h4,   1'b1, 2'd0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{BASE + 32'h18,  1'b1, 2'd0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{BASE + 32'hC,   1'b1, 2'd2, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{32'h1003_0010,  1'b1, 2'd0, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{BASE + 32'h1,   1'b1, 2'd0, 1'b0, 1'b0, 32'h0};

    reset       = 1'b1;
    mmio_enable = 1'b0;
    mmio_addr   = '0;
    mmio_width  = '0;
    mmio_value  = '0;
    tx_ready    = 1'b0;

    // Reset: a pending DATA write must not be acknowledged.
    tick();
    mmio_enable = 1'b1;
    mmio_addr   = DATA_A;
    mmio_value  = 32'hAA;
    repeat (3) begin
      #1;
      chk("rst_complete", {31'd0, mmio_write_complete}, 32'd0);
      chk("rst_avail", {31'd0, tx_data_available}, 32'd0);
      tick();
    end
    reset       = 1'b0;
    mmio_enable = 1'b0;
    rd_check("post_rst_status", STATUS_A, 32'h1);
    rd_check("post_rst_ctrl", CTRL_A, 32'h1);

    // Decode / read-data table, applied between edges so writes have no effect.
    mmio_value = 32'h55;
    for (int i = 0; i < 12; i++) begin
      mmio_addr   = vecs[i].addr;
      mmio_enable = vecs[i].en;
      mmio_width  = vecs[i].width;
      #1;
      chk($sformatf("vec%0d_hit", i), {31'd0, mmio_hit}, {31'd0, vecs[i].exp_hit});
      chk($sformatf("vec%0d_cmp", i), {31'd0, mmio_write_complete}, {31'd0, vecs[i].exp_cmp});
      chk($sformatf("vec%0d_rdata", i), mmio_r_data, vecs[i].exp_rdata);
    end
    mmio_enable = 1'b0;
    mmio_width  = 2'd0;
    tick();

    // Two bytes with the transmitter ready; one-cycle push latency.
    pops0       = n_pops;
    tx_ready    = 1'b1;
    mmio_addr   = DATA_A;
    mmio_width  = 2'd0;
    mmio_value  = 32'h48;
    mmio_enable = 1'b1;
    #1;
    chk("h_complete", {31'd0, mmio_write_complete}, 32'd1);
    chk("h_no_bypass", {31'd0, tx_data_available}, 32'd0);
    exp_q.push_back(8'h48);
    tick();
    mmio_enable = 1'b0;
    chk("h_avail", {31'd0, tx_data_available}, 32'd1);
    chk("h_data", {24'd0, tx_data}, 32'h48);
    bus_write(DATA_A, 2'd0, 32'h69, 4, w);
    chk("i_avail", {31'd0, tx_data_available}, 32'd1);
    chk("i_data", {24'd0, tx_data}, 32'h69);
    tick();
    chk("hi_empty_avail", {31'd0, tx_data_available}, 32'd0);
    rd_check("hi_status", STATUS_A, 32'h1);
    chk("hi_pops", 32'(n_pops - pops0), 32'd2);
    tick();

    // Fill to DEPTH, then a stalled write released by a single pop.
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) bus_write(DATA_A, 2'd0, 32'(8'h10 + i), 4, w);
    rd_check("full_status", STATUS_A, exp_status());
    chk("full_status_const", mmio_r_data, 32'h0000_100A);
    mmio_addr   = DATA_A;
    mmio_value  = 32'h77;
    mmio_enable = 1'b1;
    #1;
    chk("stall_cmp0", {31'd0, mmio_write_complete}, 32'd0);
    repeat (3) begin
      tick();
      chk("stall_cmp", {31'd0, mmio_write_complete}, 32'd0);
    end
    tx_ready = 1'b1;
    #1;
    chk("stall_pop_cycle_cmp", {31'd0, mmio_write_complete}, 32'd0);
    tick();
    tx_ready = 1'b0;
    chk("stall_release", {31'd0, mmio_write_complete}, 32'd1);
    exp_q.push_back(8'h77);
    tick();
    mmio_enable = 1'b0;
    rd_check("refull_status", STATUS_A, exp_status());
    wait_drain();
    tick();

    // Reset while full and stalled.
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) bus_write(DATA_A, 2'd0, 32'($urandom_range(0, 255)), 4, w);
    mmio_addr   = DATA_A;
    mmio_value  = 32'hC3;
    mmio_enable = 1'b1;
    #1;
    chk("rs_stall", {31'd0, mmio_write_complete}, 32'd0);
    tick();
    reset    = 1'b1;
    tx_ready = 1'b1;
    repeat (2) begin
      #1;
      chk("rs_complete", {31'd0, mmio_write_complete}, 32'd0);
      chk("rs_avail", {31'd0, tx_data_available}, 32'd0);
      tick();
    end
    reset       = 1'b0;
    mmio_enable = 1'b0;
    tx_ready    = 1'b0;
    exp_q.delete();
    exp_en   = 1'b1;
    exp_werr = 1'b0;
    rd_check("rs_status", STATUS_A, 32'h1);
    rd_check("rs_ctrl", CTRL_A, 32'h1);
    tick();

    // 40 random bytes with random transmitter back-pressure.
    pops0 = n_pops;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          bus_write(DATA_A, 2'd0, 32'($urandom_range(0, 255)), 200, w);
          repeat ($urandom_range(0, 2)) tick();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tx_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    wait_drain();
    chk("rand_pops", 32'(n_pops - pops0), 32'd40);
    tick();

    // Wide writes to DATA and width_err clearing.
    tx_ready = 1'b0;
    bus_write(DATA_A, 2'd2, 32'hDEAD_BEEF, 4, w);
    chk("word_immediate", 32'(w), 32'd0);
    rd_check("werr_status", STATUS_A, exp_status());
    chk("werr_status_const", mmio_r_data, 32'h5);
    bus_write(DATA_A, 2'd1, 32'h0000_1234, 4, w);
    chk("half_immediate", 32'(w), 32'd0);
    bus_write(STATUS_A, 2'd2, 32'h0, 4, w);
    rd_check("werr_kept", STATUS_A, exp_status());
    bus_write(STATUS_A, 2'd2, 32'h1, 4, w);
    rd_check("werr_cleared", STATUS_A, 32'h1);

    // tx_enable gating and flush.
    bus_write(DATA_A, 2'd0, 32'hA1, 4, w);
    bus_write(DATA_A, 2'd0, 32'hA2, 4, w);
    bus_write(DATA_A, 2'd0, 32'hA3, 4, w);
    bus_write(CTRL_A, 2'd2, 32'h0, 4, w);
    tx_ready = 1'b1;
    repeat (3) tick();
    chk("dis_avail", {31'd0, tx_data_available}, 32'd0);
    rd_check("dis_status", STATUS_A, exp_status());
    chk("dis_count3", mmio_r_data, 32'h300);
    rd_check("dis_ctrl", CTRL_A, 32'h0);
    bus_write(CTRL_A, 2'd2, 32'h1, 4, w);
    chk("en_avail", {31'd0, tx_data_available}, 32'd1);
    rd_check("en_status", STATUS_A, exp_status());
    tick();
    tx_ready = 1'b0;
    rd_check("en_one_pop", STATUS_A, exp_status());
    chk("en_one_pop_const", mmio_r_data, 32'h208);
    bus_write(CTRL_A, 2'd2, 32'h2, 4, w);
    rd_check("flush_status", STATUS_A, 32'h1);
    rd_check("flush_ctrl", CTRL_A, 32'h0);
    bus_write(DATA_A, 2'd0, 32'h5A, 4, w);
    chk("dis_push_avail", {31'd0, tx_data_available}, 32'd0);
    rd_check("dis_push_status", STATUS_A, 32'h100);
    bus_write(CTRL_A, 2'd2, 32'h1, 4, w);
    wait_drain();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the FIFO depth in bytes (power of two, 2..256).
REQ-002 Parameter BASE_ADDR, default 32'h00030000, SHALL set the address of the DATA register.
REQ-003 core_clock  input  1  SHALL be the single clock for the block, rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset sampled on core_clock.
REQ-005 mmio_addr  input  32  SHALL be the MMIO byte address from the hart.
REQ-006 mmio_enable  input  1  SHALL be the write request; the hart holds it, with all other mmio_* inputs stable, until mmio_write_complete.
REQ-007 mmio_width  input  2  SHALL be the write width: 0 byte, 1 half, 2 word.
REQ-008 mmio_value  input  32  SHALL be the write data.
REQ-009 mmio_hit  output  1  SHALL flag that mmio_addr decodes to DATA, STATUS (BASE_ADDR+0x10) or CTRL (BASE_ADDR+0x14).
REQ-010 mmio_write_complete  output  1  SHALL be the combinational write acknowledge.
REQ-011 mmio_r_data  output  32  SHALL be the combinational read data for mmio_addr.
REQ-012 tx_data  output  8  SHALL carry the FIFO head byte to serial_transmitter.
REQ-013 tx_data_available  output  1  SHALL flag that tx_data is valid.
REQ-014 tx_ready  input  1  SHALL flag that serial_transmitter accepts a byte this cycle.

Function
REQ-015 Writes SHALL be handled as follows: a byte write to DATA while the FIFO is not full SHALL complete in the same cycle and push value[7:0] at the next edge.
REQ-016 A byte write to DATA while the FIFO is full SHALL hold mmio_write_complete low (stall) until a pop frees space; fullness SHALL be the registered value, so a push and a pop in the same cycle from full SHALL NOT both occur.
REQ-017 A half or word write to DATA SHALL complete immediately, push nothing, and set sticky STATUS.width_err.
REQ-018 A write to STATUS SHALL complete immediately and clear width_err when value[0]=1.
REQ-019 A write to CTRL SHALL complete immediately and load tx_enable from value[0].
REQ-020 A write to CTRL with value[1]=1 SHALL flush the FIFO: count to 0 and pointers equal, with no pop to the transmitter that cycle.
REQ-021 For an undecoded address, mmio_hit and mmio_write_complete SHALL be 0.
REQ-022 mmio_r_data SHALL present, at STATUS: bit0 empty, bit1 full, bit2 width_err, bit3 tx_busy (tx_data_available), bits[16:8] count, all other bits 0.
REQ-023 mmio_r_data SHALL present, at CTRL: bit0 tx_enable, all other bits 0; it SHALL read 0 at any other address, including DATA.
REQ-024 The FIFO SHALL be a circular buffer with read/write pointers of clog2(DEPTH) bits that wrap modulo DEPTH, plus a count of clog2(DEPTH)+1 bits in the range 0..DEPTH.
REQ-025 tx_data_available SHALL equal (count != 0) && tx_enable, and tx_data SHALL equal the mem[read pointer] value, registered with no combinational bypass from mmio_value.
REQ-026 A pop SHALL occur on every cycle with tx_data_available && tx_ready; a simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-027 A push to an empty FIFO SHALL make tx_data_available high no earlier than the following cycle (1-cycle latency).
REQ-028 Clearing tx_enable SHALL deassert tx_data_available in the same cycle, retain the FIFO contents, and still accept pushes.
REQ-029 Bytes SHALL leave in push order, with no loss or duplication, across pointer wrap.

Reset
REQ-030 While reset is high, count, pointers and width_err SHALL be 0, tx_enable SHALL be 1, and no push or pop SHALL occur.
REQ-031 While reset is high, tx_data_available and mmio_write_complete SHALL be 0.
REQ-032 Reset asserted mid-stall or mid-drain SHALL discard all buffered bytes, and the first post-reset cycle SHALL show empty=1.
REQ-033 FIFO storage SHALL need no reset, and tx_data SHALL be don't-care while tx_data_available=0.

Verification
REQ-034 Bench: byte writes 0x48, 0x69 with tx_ready=1 -> tx_data 0x48 then 0x69, one pop each, STATUS reads empty=1 after.
REQ-035 Bench: tx_ready=0 and DEPTH=16 byte writes -> STATUS full=1 and count=16; the 17th write stalls until tx_ready=1 for one cycle, then completes the next cycle.
REQ-036 Bench: 40 bytes with tx_ready toggling randomly -> the output sequence equals the input sequence across pointer wrap.
REQ-037 Bench: word write to DATA -> immediate complete, count unchanged, width_err=1; STATUS write of 1 -> width_err=0.
REQ-038 Bench: CTRL=0 with 3 bytes queued -> tx_data_available=0 and count=3; CTRL=1 -> drain resumes; CTRL=2 -> count=0 and tx_enable=0.
REQ-039 Bench: reset asserted while full and stalled -> complete=0 and available=0 during reset, then count=0 and tx_enable=1 after reset.
